ccsds123_ctrl: RTL
==================

Name: ccsds123_ctrl

Overview:
- Image sequencer in front of the PIPELINES-wide ccsds123 datapath.
- Gates the s_axis handshake into the datapath.
- Tracks BIP-order coordinates (z fastest, then x, then y) of lane 0 of each beat and generates first/last-of-image flags and per-lane valid masks.
- Counts images in flight using m_axis_tlast beats from the encoder output and throttles input when MAX_INFLIGHT images are outstanding.
- Sample data bypasses this block; only control and sideband signals pass through it.

Parameters:
- PIPELINES, 3, samples per input beat; legal range 1..NZ.
- NX, 500, image width.
- NY, 500, image height.
- NZ, 100, band count.
- MAX_INFLIGHT, 2, maximum images accepted but not yet terminated by output tlast; must be ≥1.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tready  out  1  upstream ready.
- dp_tvalid  out  1  beat valid to datapath.
- dp_tready  in  1  datapath ready.
- dp_lane_valid  out  PIPELINES  per-lane sample valid.
- dp_first  out  1  beat holds sample 0 of the image.
- dp_last  out  1  final beat of the image.
- dp_z  out  $clog2(NZ)  band of lane 0.
- dp_x  out  $clog2(NX)  column of lane 0.
- dp_y  out  $clog2(NY)  row of lane 0.
- m_axis_tvalid  in  1  encoder output valid (monitor only).
- m_axis_tready  in  1  encoder output ready (monitor only).
- m_axis_tlast  in  1  encoder output last (monitor only).
- busy  out  1  state != IDLE or inflight != 0.

Behaviour:
- Derived constants:
  - BEATS = ceil(NX*NY*NZ/PIPELINES).
  - REM = NX*NY*NZ − (BEATS−1)*PIPELINES, in the range 1..PIPELINES.
- Open gate: open = (inflight < MAX_INFLIGHT) || state == RUN.
- Handshake:
  - s_axis_tready = dp_tready && open.
  - dp_tvalid = s_axis_tvalid && open.
  - Both are purely combinational.
  - Accept event: acc = s_axis_tvalid && dp_tready && open.
- States:
  - IDLE: coordinates are zero. On acc, inflight increments; go to RUN, or stay in IDLE if BEATS==1.
  - RUN: on acc, advance the coordinates. On acc of the beat with beat_cnt==BEATS−1, return to IDLE and reset coordinates and beat_cnt to 0.
- Sideband outputs (combinational from registered state):
  - dp_first = (state==IDLE).
  - dp_last = (beat_cnt==BEATS−1).
  - dp_lane_valid = all ones, except on the last beat, where only the low REM bits are set.
- Coordinate advance on acc:
  - z ← z+PIPELINES.
  - If the result is ≥ NZ, subtract NZ and carry into x.
  - x wraps at NX with carry into y.
  - y wraps at NY.
  - At most one carry per beat, because PIPELINES ≤ NZ.
  - Arithmetic uses one guard bit; there is no modulo operator.
- In-flight counter:
  - Width $clog2(MAX_INFLIGHT+1).
  - Incremented on acc in IDLE, i.e. when the first beat of an image is accepted.
  - Decremented on done = m_axis_tvalid && m_axis_tready && m_axis_tlast.
  - Simultaneous increment and decrement leaves it unchanged.
  - done with inflight==0 is ignored, saturating at 0.
- Throttling:
  - A new image is admitted only while inflight < MAX_INFLIGHT.
  - An image already in RUN is never throttled mid-image.
- Reset values: state=IDLE; beat_cnt, z, x, y, inflight = 0; busy=0.
  - Outputs follow from these: s_axis_tready=dp_tready, dp_first=1, dp_lane_valid all ones (or REM mask if BEATS==1).
- Reset asserted mid-image: all state clears immediately and the partial image is abandoned. Upstream must restart from sample 0.
- Latency: zero-cycle pass-through of the handshake. Sideband outputs are valid in the same cycle as dp_tvalid.

Optional Feature:
- Macro: CCSDS123_CTRL_STATS_EN.
- When defined, add three outputs, each CNT_W bits:
  - stat_total: cycles with state==RUN or with s_axis_tvalid asserted.
  - stat_stall: subset of those cycles with s_axis_tvalid && !s_axis_tready.
  - stat_images: count of done events.
  - All three counters reset to 0, saturate at all-ones, and clear on aresetn.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package ccsds123_ctrl_pkg holds:
  - the state enum (IDLE, RUN);
  - functions for BEATS and REM;
  - the coordinate-width localparams.
- One natural sub-module, ccsds123_coord_cnt: the z/x/y wrapping counter with step PIPELINES and an advance/clear interface.

Test Plan:
- NX=2, NY=2, NZ=3, PIPELINES=3, no stalls → 4 beats.
  - dp_z = 0,0,0,0; dp_x = 0,1,0,1; dp_y = 0,0,1,1.
  - dp_first on beat 0, dp_last on beat 3, lane_valid=3'b111 throughout.
- NX=NY=1, NZ=5, PIPELINES=3 → 2 beats; second beat has dp_z=3, dp_lane_valid=3'b011, dp_last=1.
- MAX_INFLIGHT=1, two images back-to-back, m_axis_tlast withheld → after image 1 completes, s_axis_tready=0. Assert done for one cycle → s_axis_tready=1 in the same cycle the counter drops to 0, and image 2 begins with dp_first=1.
- dp_tready toggled randomly at 50% mid-image → coordinates advance only on acc; the sequence is identical to the no-stall run.
- aresetn pulsed low after 2 beats of a 4-beat image → state=IDLE, dp_first=1, inflight=0, coordinates zero; a fresh image then runs correctly.
- With CCSDS123_CTRL_STATS_EN: hold dp_tready=0 for 5 cycles with s_axis_tvalid=1, then release → stat_stall=5 and stat_total counts every cycle until the image ends.

Source files
------------

// File: rtl/ccsds123_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the ccsds123 image sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: state enum, beat/remainder helpers, coordinate-width helper and defaults.
package ccsds123_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of a counter holding 0..n-1; never narrower than one bit so that
  // degenerate dimensions (n==1) still produce a legal port.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beats needed to carry one whole image, PIPELINES samples per beat.
  function automatic int beats_f(input int nx, input int ny, input int nz, input int p);
    return (nx * ny * nz + p - 1) / p;
  endfunction

  // Valid samples in the final beat, 1..p.
  function automatic int rem_f(input int nx, input int ny, input int nz, input int p);
    return nx * ny * nz - (beats_f(nx, ny, nz, p) - 1) * p;
  endfunction

  // Coordinate widths for the default image geometry.
  localparam int NX_DEF = 500;
  localparam int NY_DEF = 500;
  localparam int NZ_DEF = 100;
  localparam int XW_DEF = coord_w(NX_DEF);
  localparam int YW_DEF = coord_w(NY_DEF);
  localparam int ZW_DEF = coord_w(NZ_DEF);

endpackage

// File: rtl/ccsds123_coord_cnt.sv
// BIP-order (z fastest, then x, then y) coordinate counter stepping z by P.
// Latency: coordinates update on the clock edge after adv/clr.
// Backpressure: none; advances only when the parent asserts adv.
// Ports: clk, aresetn, adv (step once), clr (back to origin, wins over adv),
//        z/x/y current coordinate of lane 0.
module ccsds123_coord_cnt
  import ccsds123_ctrl_pkg::*;
#(
  parameter int P  = 3,
  parameter int NX = 500,
  parameter int NY = 500,
  parameter int NZ = 100
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   adv,
  input  logic                   clr,
  output logic [coord_w(NZ)-1:0] z,
  output logic [coord_w(NX)-1:0] x,
  output logic [coord_w(NY)-1:0] y
);

  localparam int ZW = coord_w(NZ);
  localparam int XW = coord_w(NX);
  localparam int YW = coord_w(NY);

  // One guard bit is enough: z < NZ and P <= NZ, so z+P < 2*NZ.
  logic [ZW:0]   z_sum;
  logic [XW:0]   x_inc;
  logic [YW:0]   y_inc;
  logic          z_carry;
  logic          x_carry;
  logic          y_wrap;
  logic [ZW-1:0] z_next;

  assign z_sum   = {1'b0, z} + (ZW+1)'(P);
  assign z_carry = (z_sum >= (ZW+1)'(NZ));
  assign z_next  = z_carry ? ZW'(z_sum - (ZW+1)'(NZ)) : z_sum[ZW-1:0];
  assign x_inc   = {1'b0, x} + (XW+1)'(1);
  assign x_carry = (x_inc == (XW+1)'(NX));
  assign y_inc   = {1'b0, y} + (YW+1)'(1);
  assign y_wrap  = (y_inc == (YW+1)'(NY));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      z <= '0;
      x <= '0;
      y <= '0;
    end else if (clr) begin
      z <= '0;
      x <= '0;
      y <= '0;
    end else if (adv) begin
      z <= z_next;
      if (z_carry) begin
        if (x_carry) begin
          x <= '0;
          y <= y_wrap ? '0 : y_inc[YW-1:0];
        end else begin
          x <= x_inc[XW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ccsds123_ctrl.sv
// Image sequencer: gates s_axis into the datapath, tags beats with z/x/y, first/last, lane mask.
// Latency: zero-cycle handshake pass-through; sideband valid with dp_tvalid.
// Backpressure: ready follows dp_tready; new images held off while MAX_INFLIGHT are outstanding.
// Ports: s_axis_tvalid/tready upstream, dp_* to datapath, m_axis_* monitored for image
//        completion, busy. Optional CCSDS123_CTRL_STATS_EN adds stat_total/stat_stall/stat_images.
module ccsds123_ctrl
  import ccsds123_ctrl_pkg::*;
#(
  parameter int PIPELINES    = 3,
  parameter int NX           = 500,
  parameter int NY           = 500,
  parameter int NZ           = 100,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic                   dp_tvalid,
  input  logic                   dp_tready,
  output logic [PIPELINES-1:0]   dp_lane_valid,
  output logic                   dp_first,
  output logic                   dp_last,
  output logic [coord_w(NZ)-1:0] dp_z,
  output logic [coord_w(NX)-1:0] dp_x,
  output logic [coord_w(NY)-1:0] dp_y,
  input  logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic                   m_axis_tlast,
  output logic                   busy
`ifdef CCSDS123_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]       stat_total,
  output logic [CNT_W-1:0]       stat_stall,
  output logic [CNT_W-1:0]       stat_images
`endif
);

  localparam int BEATS = beats_f(NX, NY, NZ, PIPELINES);
  localparam int REM   = rem_f(NX, NY, NZ, PIPELINES);
  localparam int BW    = coord_w(BEATS);
  localparam int IW    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [PIPELINES-1:0] LAST_MASK = {PIPELINES{1'b1}} >> (PIPELINES - REM);

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic [IW-1:0] inflight;
  logic          open;
  logic          acc;
  logic          done;
  logic          inc;
  logic          dec;

  // An image already running is never cut off mid-image by the in-flight limit.
  assign open          = (inflight < IW'(MAX_INFLIGHT)) || (state == RUN);
  assign s_axis_tready = dp_tready && open;
  assign dp_tvalid     = s_axis_tvalid && open;
  assign acc           = s_axis_tvalid && dp_tready && open;
  assign done          = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  assign dp_first      = (state == IDLE);
  assign dp_last       = (beat_cnt == BW'(BEATS - 1));
  assign dp_lane_valid = dp_last ? LAST_MASK : {PIPELINES{1'b1}};
  assign busy          = (state != IDLE) || (inflight != '0);

  // First beat of an image is the one accepted in IDLE; a done with nothing
  // outstanding is dropped so the counter cannot underflow.
  assign inc = acc && (state == IDLE);
  assign dec = done && (inflight != '0);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      inflight <= '0;
    end else begin
      if (acc) begin
        if (dp_last) begin
          state    <= IDLE;
          beat_cnt <= '0;
        end else begin
          state    <= RUN;
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
      if (inc && !dec) begin
        inflight <= inflight + IW'(1);
      end else if (dec && !inc) begin
        inflight <= inflight - IW'(1);
      end
    end
  end

  ccsds123_coord_cnt #(
    .P  (PIPELINES),
    .NX (NX),
    .NY (NY),
    .NZ (NZ)
  ) u_coord (
    .clk     (clk),
    .aresetn (aresetn),
    .adv     (acc),
    .clr     (acc && dp_last),
    .z       (dp_z),
    .x       (dp_x),
    .y       (dp_y)
  );

`ifdef CCSDS123_CTRL_STATS_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stat_total  <= '0;
      stat_stall  <= '0;
      stat_images <= '0;
    end else begin
      if (((state == RUN) || s_axis_tvalid) && (stat_total != '1)) begin
        stat_total <= stat_total + CNT_W'(1);
      end
      if (s_axis_tvalid && !s_axis_tready && (stat_stall != '1)) begin
        stat_stall <= stat_stall + CNT_W'(1);
      end
      if (done && (stat_images != '1)) begin
        stat_images <= stat_images + CNT_W'(1);
      end
    end
  end
`endif

endmodule
